// File: rtl/spi_fsm.sv
// spi_fsm -- transaction controller for the SPI memory datapath.
//
// Sequences one SPI transaction: a DATA_WIDTH-bit address + R/W phase, then
// either a read (parallel-load the shift register, enable MISO for
// DATA_WIDTH SCLK rising edges) or a write (collect DATA_WIDTH bits, then
// pulse the data-memory write enable). Chip-select deassertion returns the
// controller to IDLE from any state.
//
// Ports:
//   clk              system clock, rising edge
//   reset_n          asynchronous active-low reset
//   csConditioned    synchronized chip select, active low
//   sclkPosEdge      one-clk strobe per SCLK rising edge (counted)
//   sclkNegEdge      one-clk strobe per SCLK falling edge (not used for state)
//   shiftRegPOut     shift register parallel output; bit 0 = R/W after address
//   addrLatchEnable  address latch capture enable
//   srParallelLoad   shift register parallel load
//   misoBufferEnable tri-state MISO buffer enable
//   dmWriteEnable    data-memory write enable
//   abortFlag        (only with SPI_FSM_ABORT_FLAG_EN) 1-clk pulse after CS
//                    deasserts in the middle of a transaction
//
// Optional feature macro: SPI_FSM_ABORT_FLAG_EN

module spi_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  csConditioned,
  input  logic                  sclkPosEdge,
  input  logic                  sclkNegEdge,
  input  logic [DATA_WIDTH-1:0] shiftRegPOut,
  output logic                  addrLatchEnable,
  output logic                  srParallelLoad,
  output logic                  misoBufferEnable,
  output logic                  dmWriteEnable
`ifdef SPI_FSM_ABORT_FLAG_EN
  ,
  output logic                  abortFlag
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_MEM,
    DONE
  } stateT;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  stateT                state;
  stateT                stateNext;
  logic [CNT_WIDTH-1:0] bitCount;
  logic [CNT_WIDTH-1:0] bitCountNext;

  // The falling-edge strobe only clocks the external MISO flop, and only the
  // R/W bit of the shift register matters here.
  logic unusedInputs;
  assign unusedInputs = ^{sclkNegEdge, shiftRegPOut[DATA_WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bitCount <= '0;
    end else begin
      state    <= stateNext;
      bitCount <= bitCountNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext    = state;
    bitCountNext = bitCount;
    if (csConditioned) begin
      // CS deassertion wins over every other transition.
      stateNext    = IDLE;
      bitCountNext = '0;
    end else begin
      unique case (state)
        IDLE: begin
          stateNext    = GET_ADDR;
          bitCountNext = '0;
        end
        GET_ADDR, READ_SHIFT, WRITE_GET: begin
          if (sclkPosEdge) begin
            if (bitCount == LAST_BIT) begin
              bitCountNext = '0;
              unique case (state)
                GET_ADDR:   stateNext = GOT_ADDR;
                READ_SHIFT: stateNext = DONE;
                default:    stateNext = WRITE_MEM;
              endcase
            end else begin
              bitCountNext = bitCount + 1'b1;
            end
          end
        end
        GOT_ADDR: begin
          stateNext    = shiftRegPOut[0] ? READ_LOAD : WRITE_GET;
          bitCountNext = '0;
        end
        READ_LOAD: stateNext = READ_SHIFT;
        WRITE_MEM: stateNext = DONE;
        DONE:      stateNext = DONE;
        default: begin
          stateNext    = IDLE;
          bitCountNext = '0;
        end
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    addrLatchEnable  = 1'b0;
    srParallelLoad   = 1'b0;
    misoBufferEnable = 1'b0;
    dmWriteEnable    = 1'b0;
    unique case (state)
      GOT_ADDR:   addrLatchEnable  = 1'b1;
      READ_LOAD:  srParallelLoad   = 1'b1;
      READ_SHIFT: misoBufferEnable = 1'b1;
      WRITE_MEM:  dmWriteEnable    = 1'b1;
      default:    ;
    endcase
  end

`ifdef SPI_FSM_ABORT_FLAG_EN
  logic midTransaction;
  assign midTransaction = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abortFlag <= 1'b0;
    end else begin
      abortFlag <= csConditioned && midTransaction;
    end
  end
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm -- scoreboard bench for spi_fsm. Stimulus pushes the expected
// output pulses; a monitor groups each run of a nonzero output code and
// compares its code, length in clocks, the posedge-strobe index at which it
// started (strobes since CS fell) and the strobes seen during the run.

module tb_spi_fsm;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          csConditioned;
  logic          sclkPosEdge;
  logic          sclkNegEdge;
  logic [DW-1:0] shiftRegPOut;
  logic          addrLatchEnable;
  logic          srParallelLoad;
  logic          misoBufferEnable;
  logic          dmWriteEnable;
  logic          abortBit;

  spi_fsm #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .csConditioned    (csConditioned),
    .sclkPosEdge      (sclkPosEdge),
    .sclkNegEdge      (sclkNegEdge),
    .shiftRegPOut     (shiftRegPOut),
    .addrLatchEnable  (addrLatchEnable),
    .srParallelLoad   (srParallelLoad),
    .misoBufferEnable (misoBufferEnable),
    .dmWriteEnable    (dmWriteEnable)
`ifdef SPI_FSM_ABORT_FLAG_EN
    ,
    .abortFlag        (abortBit)
`endif
  );

`ifndef SPI_FSM_ABORT_FLAG_EN
  assign abortBit = 1'b0;
`endif

  always #5 clk = ~clk;

  localparam logic [4:0] C_ABORT = 5'b10000;
  localparam logic [4:0] C_ALE   = 5'b01000;
  localparam logic [4:0] C_SRL   = 5'b00100;
  localparam logic [4:0] C_MISO  = 5'b00010;
  localparam logic [4:0] C_DMWE  = 5'b00001;

  typedef struct {
    logic [4:0] code;
    int         len;
    int         startIdx;
    int         strobes;
  } runT;

  runT expQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  logic [4:0] outCode;
  assign outCode = {abortBit, addrLatchEnable, srParallelLoad, misoBufferEnable, dmWriteEnable};

  task automatic expectRun(input logic [4:0] code, input int len, input int startIdx, input int strobes);
    runT r;
    r.code = code; r.len = len; r.startIdx = startIdx; r.strobes = strobes;
    expQ.push_back(r);
  endtask

  task automatic checkOuts(input string name, input logic [4:0] act, input logic [4:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: outputs=%b required=%b", name, act, req);
    end
  endtask

  // Monitor: sample on the falling clock edge.
  initial begin
    bit   inRun = 0;
    runT  cur;
    runT  exp;
    int   posCnt = 0;
    forever begin
      @(negedge clk);
      if (inRun && outCode != cur.code) begin
        inRun = 0;
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_run: code=%b len=%0d start=%0d strobes=%0d, none required",
                   cur.code, cur.len, cur.startIdx, cur.strobes);
        end else begin
          exp = expQ.pop_front();
          if (cur.code != exp.code || cur.len != exp.len ||
              cur.startIdx != exp.startIdx || cur.strobes != exp.strobes) begin
            mismatched++;
            $display("FAIL run_%b: got code=%b len=%0d start=%0d strobes=%0d required code=%b len=%0d start=%0d strobes=%0d",
                     exp.code, cur.code, cur.len, cur.startIdx, cur.strobes,
                     exp.code, exp.len, exp.startIdx, exp.strobes);
          end
        end
      end
      if (!inRun && outCode != 5'b0) begin
        inRun = 1;
        cur.code = outCode; cur.len = 0; cur.startIdx = posCnt; cur.strobes = 0;
      end
      if (inRun) begin
        cur.len++;
        if (sclkPosEdge) cur.strobes++;
      end
      if (csConditioned) posCnt = 0;
      else if (sclkPosEdge) posCnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic posStrobe(input bit withNeg);
    sclkPosEdge = 1'b1;
    sclkNegEdge = withNeg;
    tick();
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    repeat (3) tick();
  endtask

  task automatic addrPhase(input logic [DW-1:0] pout, input bit withNeg);
    shiftRegPOut = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (i == DW - 1) shiftRegPOut = pout;
      posStrobe(withNeg);
    end
  endtask

  task automatic endCs();
    csConditioned = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0; csConditioned = 1'b1;
    sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; shiftRegPOut = '0;
    repeat (3) tick();
    checkOuts("reset_state", outCode, 5'b0);
    reset_n = 1'b1;
    repeat (2) tick();
    checkOuts("idle_after_reset", outCode, 5'b0);

    // Reset during WRITE_GET: only the address latch pulse may appear.
    expectRun(C_ALE, 1, 8, 0);
    csConditioned = 1'b0; tick();
    addrPhase(8'b0000_0000, 0);
    for (int unsigned i = 0; i < 4; i++) posStrobe(0);
    #3;
    reset_n = 1'b0;
    #1;
    checkOuts("reset_async_clear", outCode, 5'b0);
    csConditioned = 1'b1;
    repeat (2) tick();
    checkOuts("reset_hold", outCode, 5'b0);
    reset_n = 1'b1;
    repeat (3) tick();
    checkOuts("post_reset_idle", outCode, 5'b0);

    // Read transaction.
    expectRun(C_ALE, 1, 8, 0);
    expectRun(C_SRL, 1, 8, 0);
    expectRun(C_MISO, 30, 8, 8);
    csConditioned = 1'b0; tick();
    addrPhase(8'b1010_0111, 0);
    for (int unsigned i = 0; i < DW; i++) posStrobe(0);
    repeat (4) tick();
    checkOuts("read_done_quiet", outCode, 5'b0);
    endCs();

    // Abort after 3 address strobes.
`ifdef SPI_FSM_ABORT_FLAG_EN
    expectRun(C_ABORT, 1, 0, 0);
`endif
    csConditioned = 1'b0; tick();
    for (int unsigned i = 0; i < 3; i++) posStrobe(0);
    endCs();

    // Falling-edge-only pulses are ignored, coincident strobes count once.
    expectRun(C_ALE, 1, 8, 0);
    expectRun(C_DMWE, 1, 16, 0);
    csConditioned = 1'b0; tick();
    for (int unsigned i = 0; i < 10; i++) begin
      sclkNegEdge = 1'b1; tick();
      sclkNegEdge = 1'b0; tick();
    end
    addrPhase(8'b0101_0110, 1);
    for (int unsigned i = 0; i < DW; i++) posStrobe(1);
    repeat (2) tick();

    // CS held low after DONE: strobes must not restart anything.
    for (int unsigned i = 0; i < 20; i++) posStrobe(0);
    checkOuts("done_hold", outCode, 5'b0);

    // CS high then low: fresh write transaction.
    expectRun(C_ALE, 1, 8, 0);
    expectRun(C_DMWE, 1, 16, 0);
    csConditioned = 1'b1; tick();
    csConditioned = 1'b0; tick();
    addrPhase(8'b1111_1110, 0);
    for (int unsigned i = 0; i < DW; i++) posStrobe(0);
    endCs();

    repeat (5) tick();
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL pending_runs: outstanding=%0d required=0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
Transaction controller for the SPI memory datapath. It consumes the conditioned chip-select, the SCLK edge strobes, and the 8-bit parallel output of the upstream shift register. It sequences address capture, the read/write decision, shift-register parallel load, MISO drive enable and data-memory write enable. The block sits directly downstream of the shift register and drives its parallelLoad input.

Parameters:
- DATA_WIDTH, 8, bits shifted per phase (address+R/W phase and data phase); also the shift-register width.
- CNT_WIDTH, 4, bit-counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- csConditioned  input  1  synchronized chip select, active low.
- sclkPosEdge  input  1  one-clk strobe per SCLK rising edge; the same strobe drives the shift register's peripheralClkEdge.
- sclkNegEdge  input  1  one-clk strobe per SCLK falling edge.
- shiftRegPOut  input  DATA_WIDTH  shift register parallelDataOut; bit 0 is the R/W bit after the address phase.
- addrLatchEnable  output  1  address latch capture enable.
- srParallelLoad  output  1  drives shift register parallelLoad.
- misoBufferEnable  output  1  enables the tri-state MISO buffer.
- dmWriteEnable  output  1  data-memory write enable.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, bitCount=0.
  - All outputs 0 immediately.
- States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_MEM, DONE. Outputs are decoded from the registered state (Moore).
- IDLE:
  - All outputs 0.
  - csConditioned=0 -> GET_ADDR, bitCount cleared.
- GET_ADDR:
  - bitCount increments on each sclkPosEdge.
  - On the strobe where bitCount==DATA_WIDTH-1 -> GOT_ADDR, bitCount cleared.
- GOT_ADDR (exactly 1 clk):
  - addrLatchEnable=1.
  - shiftRegPOut[0]=1 -> READ_LOAD; shiftRegPOut[0]=0 -> WRITE_GET.
- READ_LOAD (exactly 1 clk):
  - srParallelLoad=1; next READ_SHIFT.
- READ_SHIFT:
  - misoBufferEnable=1.
  - Counts sclkPosEdge; after DATA_WIDTH strobes -> DONE.
  - sclkNegEdge has no effect on state; it is used only by the external MISO flop.
- WRITE_GET:
  - Counts DATA_WIDTH sclkPosEdge strobes -> WRITE_MEM.
- WRITE_MEM (exactly 1 clk):
  - dmWriteEnable=1; next DONE.
- DONE:
  - All outputs 0; waits for csConditioned=1 -> IDLE.
- Boundary conditions:
  - csConditioned=1 in any state: next state IDLE, bitCount=0; overrides every other transition, including one-cycle states.
  - sclkPosEdge and sclkNegEdge high in the same cycle: only the posedge is counted.
  - sclkPosEdge while in a one-cycle state (GOT_ADDR, READ_LOAD, WRITE_MEM) or DONE: ignored, not counted.
  - bitCount never exceeds DATA_WIDTH-1.
  - csConditioned=0 held after DONE: the block stays in DONE; a new transaction requires CS to deassert first.
  - Output exclusivity: at most one output is high in any cycle.

Optional Feature:
- Macro: SPI_FSM_ABORT_FLAG_EN
- Defined:
  - Extra output abortFlag (1 bit), reset 0.
  - Pulses high for exactly 1 clk in the cycle after csConditioned is seen high while the state is GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET or WRITE_MEM.
  - No pulse for CS deassertion in IDLE or DONE.
- Undefined:
  - Port absent; behaviour otherwise identical.

Test Plan:
- Reset mid-transaction: reset_n=0 asserted during WRITE_GET -> all outputs 0 within the same cycle, state IDLE after release, no dmWriteEnable.
- Read transaction: CS low, 8 posedge strobes with shiftRegPOut=8'b10100111 at the 8th -> addrLatchEnable 1 clk, then srParallelLoad 1 clk, then misoBufferEnable high for exactly 8 posedge strobes, then DONE with all outputs 0.
- Write transaction: CS low, 8 strobes with shiftRegPOut[0]=0, 8 more strobes -> addrLatchEnable once, dmWriteEnable exactly 1 clk after the 16th strobe, srParallelLoad never high.
- Abort: CS high after 3 address strobes -> IDLE next clk, no enables asserted; with SPI_FSM_ABORT_FLAG_EN defined, abortFlag=1 for 1 clk.
- Strobe filtering: sclkNegEdge-only pulses ×10 in GET_ADDR -> stays in GET_ADDR, bitCount=0; coincident pos+neg strobes count once each.
- Back-to-back: CS held low after DONE for 20 strobes -> stays DONE; CS high then low -> new GET_ADDR with bitCount=0.
